// File: rtl/regbank_dump_reader.sv
// Walks a register bank from address 0 to the top and streams every word out
// as bytes, most significant byte first, over a valid/ready byte channel.
module regbank_dump_reader #(
    parameter int ADDR_BITS = 5,
    parameter int WORD_WIDE = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    output logic [ADDR_BITS-1:0] rdAddr,
    input  logic [WORD_WIDE-1:0] rdData,
    output logic [7:0]           txData,
    output logic                 txValid,
    input  logic                 txReady,
    output logic                 busy,
    output logic                 done
);

    localparam int BYTES    = WORD_WIDE / 8;
    localparam int CNT_BITS = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [CNT_BITS-1:0] LAST_BYTE = CNT_BITS'(BYTES - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SEND, FINISH} state_t;

    state_t                state;
    logic [WORD_WIDE-1:0]  shiftReg;
    logic [CNT_BITS-1:0]   byteCnt;

    // The outgoing byte is always the top of the snapshot register.
    assign txData = shiftReg[WORD_WIDE-1 -: 8];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            rdAddr   <= '0;
            shiftReg <= '0;
            byteCnt  <= '0;
            txValid  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        rdAddr <= '0;
                        busy   <= 1'b1;
                        state  <= LOAD;
                    end
                end
                LOAD: begin
                    // Snapshot the word so later bank writes cannot corrupt it.
                    shiftReg <= rdData;
                    byteCnt  <= '0;
                    txValid  <= 1'b1;
                    state    <= SEND;
                end
                SEND: begin
                    if (txReady) begin
                        if (byteCnt != LAST_BYTE) begin
                            shiftReg <= shiftReg << 8;
                            byteCnt  <= byteCnt + CNT_BITS'(1);
                        end else if (rdAddr != '1) begin
                            rdAddr  <= rdAddr + ADDR_BITS'(1);
                            txValid <= 1'b0;
                            state   <= LOAD;
                        end else begin
                            // Top address reached: rdAddr parks here until the next start.
                            txValid <= 1'b0;
                            done    <= 1'b1;
                            state   <= FINISH;
                        end
                    end
                end
                FINISH: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    txValid <= 1'b0;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regbank_dump_reader.sv
// Bench for regbank_dump_reader: a bank model feeds rdData, a monitor captures
// the transferred bytes, and each dump is compared with the bank snapshot order.
module tb_regbank_dump_reader;

    logic        clock;
    logic        reset;
    logic        start;
    logic [4:0]  rdAddr;
    logic [31:0] rdData;
    logic [7:0]  txData;
    logic        txValid;
    logic        txReady;
    logic        busy;
    logic        done;

    logic        sStart;
    logic [1:0]  sRdAddr;
    logic [15:0] sRdData;
    logic [7:0]  sTxData;
    logic        sTxValid;
    logic        sTxReady;
    logic        sBusy;
    logic        sDone;

    logic [31:0] bank [32];
    logic [15:0] smallBank [4];

    assign rdData  = bank[rdAddr];
    assign sRdData = smallBank[sRdAddr];

    regbank_dump_reader dut (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .rdAddr (rdAddr),
        .rdData (rdData),
        .txData (txData),
        .txValid(txValid),
        .txReady(txReady),
        .busy   (busy),
        .done   (done)
    );

    regbank_dump_reader #(.ADDR_BITS(2), .WORD_WIDE(16)) dutSmall (
        .clock  (clock),
        .reset  (reset),
        .start  (sStart),
        .rdAddr (sRdAddr),
        .rdData (sRdData),
        .txData (sTxData),
        .txValid(sTxValid),
        .txReady(sTxReady),
        .busy   (sBusy),
        .done   (sDone)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int compared = 0;
    int mismatched = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: sampled at the falling edge, so it sees exactly what the next
    // rising edge will act on.
    int          cyc = 0;
    logic [7:0]  gotQ[$];
    logic [7:0]  expQ[$];
    int          loadCycs[$];
    int          doneCycs[$];
    int          lastXferCyc = -1;
    bit          holdOn = 0;
    logic [7:0]  holdByte;
    logic [4:0]  holdAddr;

    always @(negedge clock) begin
        cyc++;
        if (reset) begin
            holdOn = 0;
        end else begin
            if (holdOn) begin
                check("stall_valid", txValid, 1'b1);
                check("stall_data", txData, holdByte);
                check("stall_addr", rdAddr, holdAddr);
            end
            holdOn = 0;
            if (txValid && txReady) begin
                gotQ.push_back(txData);
                lastXferCyc = cyc;
            end else if (txValid) begin
                holdOn   = 1;
                holdByte = txData;
                holdAddr = rdAddr;
            end
            if (done) doneCycs.push_back(cyc);
            if (busy && !txValid && !done) loadCycs.push_back(cyc);
        end
    end

    logic [7:0] sGot[$];
    int         sDoneCnt = 0;

    always @(negedge clock) begin
        if (!reset) begin
            if (sTxValid && sTxReady) sGot.push_back(sTxData);
            if (sDone) sDoneCnt++;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clearMon();
        gotQ.delete();
        loadCycs.delete();
        doneCycs.delete();
        lastXferCyc = -1;
        holdOn = 0;
    endtask

    // Reference: every word in address order, MSB first, as it stands in the bank.
    task automatic buildExp();
        expQ.delete();
        for (int a = 0; a < 32; a++)
            for (int b = 0; b < 4; b++)
                expQ.push_back(bank[a][31 - 8*b -: 8]);
    endtask

    task automatic setPattern();
        for (int i = 0; i < 32; i++) bank[i] = 32'h01020300 + i;
    endtask

    task automatic compareStream(input string tag);
        check({tag, "_count"}, gotQ.size(), expQ.size());
        for (int i = 0; i < expQ.size() && i < gotQ.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), gotQ[i], expQ[i]);
    endtask

    // mode: 0 ready high, 1 ready toggling, 2 ready random.
    task automatic runDump(input int mode, input bit midStart, input int trigAddr,
                           input int wIdx, input logic [31:0] wVal, input string tag);
        int n;
        bit written;
        clearMon();
        written = 0;
        start = 1'b1;
        txReady = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (doneCycs.size() == 0 && n < 4000) begin
            if (!written && trigAddr >= 0 && int'(rdAddr) == trigAddr && txValid) begin
                bank[wIdx] = wVal;
                written = 1;
            end
            start = midStart && n >= 40 && n < 43;
            case (mode)
                0:       txReady = 1'b1;
                1:       txReady = !txReady;
                default: txReady = 1'($urandom_range(0, 1));
            endcase
            tick();
            n++;
        end
        start = 1'b0;
        check({tag, "_finished"}, n < 4000, 1'b1);
        repeat (5) tick();
        compareStream(tag);
        check({tag, "_done_pulses"}, doneCycs.size(), 1);
        check({tag, "_busy_after"}, busy, 1'b0);
        check({tag, "_addr_after"}, rdAddr, 5'd31);
        $display("dump %s: %0d bytes, %0d done pulses", tag, gotQ.size(), doneCycs.size());
    endtask

    initial begin
        int n;
        int k;
        bit hit;
        reset = 1'b1;
        start = 1'b0;
        txReady = 1'b0;
        sStart = 1'b0;
        sTxReady = 1'b1;
        setPattern();
        for (int i = 0; i < 4; i++) smallBank[i] = 16'($urandom);
        repeat (3) tick();
        check("reset_addr", rdAddr, 5'd0);
        check("reset_data", txData, 8'd0);
        check("reset_valid", txValid, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        reset = 1'b0;

        // Ready alone must not start anything.
        txReady = 1'b1;
        repeat (4) tick();
        check("idle_ready_busy", busy, 1'b0);
        check("idle_ready_valid", txValid, 1'b0);

        // Incrementing pattern with ready tied high, including timing.
        setPattern();
        buildExp();
        runDump(0, 0, -1, 0, 32'd0, "pattern");
        check("latency_160", (loadCycs.size() > 0) ? lastXferCyc - loadCycs[0] + 1 : -1, 160);
        check("done_after_last", (doneCycs.size() > 0) ? doneCycs[0] - lastXferCyc : -1, 1);

        // Same bank with ready toggling.
        runDump(1, 0, -1, 0, 32'd0, "toggle");

        // Random banks with random ready.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 32; i++) bank[i] = $urandom;
            buildExp();
            runDump(2, 0, -1, 0, 32'd0, $sformatf("random%0d", r));
        end

        // start held for three cycles mid-dump yields one dump.
        setPattern();
        buildExp();
        runDump(0, 1, -1, 0, 32'd0, "midstart");

        // Reset while byte 2 of word 5 is offered.
        clearMon();
        start = 1'b1;
        txReady = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        k = 0;
        hit = 0;
        while (!hit && n < 500) begin
            tick();
            n++;
            if (rdAddr == 5'd5 && txValid) begin
                if (k == 2) hit = 1;
                else k++;
            end
        end
        check("rst_reached", hit, 1'b1);
        reset = 1'b1;
        #1;
        check("rst_valid", txValid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_addr", rdAddr, 5'd0);
        check("rst_done", done, 1'b0);
        tick();
        tick();
        reset = 1'b0;
        repeat (10) tick();
        check("rst_no_done", doneCycs.size(), 0);
        check("rst_no_resume", busy, 1'b0);
        check("rst_partial_bytes", gotQ.size(), 22);
        $display("reset mid-dump: %0d bytes before reset", gotQ.size());
        runDump(0, 0, -1, 0, 32'd0, "after_reset");

        // start held continuously: back-to-back dumps.
        clearMon();
        start = 1'b1;
        txReady = 1'b1;
        n = 0;
        while (doneCycs.size() < 2 && n < 1000) begin
            tick();
            n++;
        end
        start = 1'b0;
        check("b2b_finished", n < 1000, 1'b1);
        repeat (5) tick();
        check("b2b_done", doneCycs.size(), 2);
        check("b2b_count", gotQ.size(), 256);
        for (int i = 0; i < 256 && i < gotQ.size(); i++)
            check($sformatf("b2b_byte%0d", i), gotQ[i], expQ[i % 128]);
        check("b2b_gap", (loadCycs.size() > 32 && doneCycs.size() > 0) ?
              loadCycs[32] - doneCycs[0] : -1, 2);
        $display("back-to-back: %0d bytes, %0d done pulses", gotQ.size(), doneCycs.size());

        // Write to word 7 during its own SEND: old value goes out.
        setPattern();
        bank[7] = 32'd0;
        buildExp();
        runDump(0, 0, 7, 7, 32'hDEADBEEF, "late_write");

        // Same write during word 3: new value goes out.
        setPattern();
        bank[7] = 32'hDEADBEEF;
        buildExp();
        bank[7] = 32'd0;
        runDump(0, 0, 3, 7, 32'hDEADBEEF, "early_write");

        // Small configuration: 4 words of 16 bits.
        sGot.delete();
        sDoneCnt = 0;
        sStart = 1'b1;
        tick();
        sStart = 1'b0;
        n = 0;
        while (sDoneCnt == 0 && n < 200) begin
            tick();
            n++;
        end
        check("small_finished", n < 200, 1'b1);
        repeat (3) tick();
        check("small_count", sGot.size(), 8);
        for (int i = 0; i < 8 && i < sGot.size(); i++)
            check($sformatf("small_byte%0d", i), sGot[i],
                  (i % 2 == 0) ? smallBank[i/2][15:8] : smallBank[i/2][7:0]);
        check("small_done", sDoneCnt, 1);
        check("small_addr", sRdAddr, 2'd3);
        check("small_busy", sBusy, 1'b0);
        $display("small dump: %0d bytes, %0d done pulses", sGot.size(), sDoneCnt);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/regbank_dump_reader.md
REGBANK_DUMP_READER -- requirements
Module: regbank_dump_reader

Interface
REQ-001 Parameter ADDR_BITS, default 5, SHALL set the register-bank address width; depth = 2^ADDR_BITS.
REQ-002 Parameter WORD_WIDE, default 32, SHALL set the word width and SHALL be a multiple of 8; BYTES = WORD_WIDE/8.
REQ-003 clock  input  1  SHALL be the clock; all state changes occur on its rising edge.
REQ-004 reset  input  1  SHALL be the reset: asynchronous, active-high.
REQ-005 start  input  1  SHALL request one full dump of the register bank.
REQ-006 rdAddr  output  ADDR_BITS  SHALL drive the bank read-port address.
REQ-007 rdData  input  WORD_WIDE  SHALL carry the combinational bank read data for rdAddr.
REQ-008 txData  output  8  SHALL carry the outgoing byte.
REQ-009 txValid  output  1  SHALL mark txData as valid.
REQ-010 txReady  input  1  SHALL indicate that the sink accepts txData in this cycle.
REQ-011 busy  output  1  SHALL be high whenever the state is not IDLE.
REQ-012 done  output  1  SHALL be a one-cycle pulse at the end of a dump.

Function
REQ-013 The FSM SHALL have the states IDLE, LOAD, SEND and FINISH.
REQ-014 IDLE: start=1 SHALL set rdAddr=0 and go to LOAD; start=0 SHALL hold IDLE.
REQ-015 LOAD: the block SHALL latch rdData into a WORD_WIDE shift register, clear byteCnt and go to SEND.
REQ-016 SEND: txValid SHALL be 1 and txData SHALL be the most significant byte of the shift register, giving MSB-first byte order.
REQ-017 Handshake: a byte transfers only on a rising edge with txValid=1 and txReady=1.
REQ-018 While txValid=1 and txReady=0, txData, rdAddr and all state SHALL hold stable.
REQ-019 On a transfer with byteCnt<BYTES-1, the block SHALL shift the register left by 8 and increment byteCnt.
REQ-020 On a transfer with byteCnt=BYTES-1 and rdAddr<depth-1, the block SHALL increment rdAddr and go to LOAD.
REQ-021 On a transfer with byteCnt=BYTES-1 and rdAddr=depth-1, the block SHALL go to FINISH; rdAddr SHALL NOT wrap.
REQ-022 FINISH: done SHALL be 1 for exactly one cycle, then the FSM SHALL go to IDLE; rdAddr SHALL hold depth-1 until the next start.
REQ-023 txValid SHALL be 0 in IDLE, LOAD and FINISH; with txReady tied high, each word SHALL take 1+BYTES cycles.
REQ-024 start SHALL be ignored when the state is not IDLE; a start level held through FINISH SHALL begin a new dump one cycle after done.
REQ-025 Snapshot rule: bank writes to a word after its LOAD edge SHALL NOT alter that word's transmitted bytes; writes to higher addresses before their LOAD SHALL be reflected in the dump.
REQ-026 txReady high while txValid=0 SHALL have no effect.

Reset
REQ-027 On reset=1, regardless of clock, the block SHALL force IDLE, rdAddr=0, txData=0, txValid=0, busy=0, done=0, shift register=0 and byteCnt=0.
REQ-028 Reset asserted during SEND SHALL drop txValid immediately, SHALL discard the partial dump, and SHALL NOT raise done.
REQ-029 After reset deasserts, the block SHALL require a new start; no dump SHALL resume.

Verification
REQ-030 Bank[i]=32'h01020300+i, txReady=1, start pulse -> 128 bytes in the order 01,02,03,00,01,02,03,01,...,01,02,03,1F; done one cycle after the last byte; 160 cycles from LOAD to the last transfer.
REQ-031 Same bank with txReady toggling 1,0,1,0 -> identical byte stream; txData stable in every stalled cycle; no byte duplicated or lost.
REQ-032 Reset asserted while sending byte 2 of word 5 -> txValid=0, busy=0 and rdAddr=0 in the same cycle; no done pulse; a later start dumps from address 0.
REQ-033 start held high for 3 cycles mid-dump -> single dump only; start held continuously -> back-to-back dumps separated by exactly one FINISH cycle and one IDLE cycle.
REQ-034 Bank[7] written with 32'hDEADBEEF during SEND of word 7 (old value 0) -> bytes 00,00,00,00 sent for word 7; the same write during word 3 -> DE,AD,BE,EF sent for word 7.
REQ-035 Parameter ADDR_BITS=2, WORD_WIDE=16 -> exactly 8 bytes, rdAddr stops at 3, done asserted once.
